aes_ctr_keystream: RTL and testbench

- Iterative AES-128 encryptor that produces a stream of CTR-mode keystream blocks from one key/IV load.
- Block i is E_K(IV with low CTR_W bits replaced by (IV_low + i) mod 2^CTR_W); the upper bits are unchanged.
- Generalises the single-shot IV encryptor: programmable block count, modular counter field, valid/ready output with backpressure.
- Sits between the key/IV register file and the payload XOR stage of the cipher datapath.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_enc_round.sv | 30 +++
 rtl/aes_key_expand_128.sv | 58 +++++
 rtl/aes_sbox.sv | 29 ++
 rtl/aes_ctr_keystream.sv | 172 +++++++++++++++++
 tb/tb_aes_ctr_keystream.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 encrypt-side definitions: FSM states, round count, round constants
// and the GF(2^8) helpers used by the round and key-schedule logic.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    RND,
    HOLD,
    FIN
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column sits in the top bits.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; the final round skips MixColumns.
module aes_enc_round (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out_c
);
  import aes_pkg::*;

  logic [7:0]   sb [16];
  logic [127:0] sr, mc;

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_sbox u_sbox (
      .a   (state_in[127-8*k -: 8]),
      .y_c (sb[k])
    );
  end

  // Byte k is row k%4, column k/4; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
    end
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  assign state_out_c = (final_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: kld loads round key 1 from the cipher key,
// then one further round key is produced per cycle up to round key 10.
module aes_key_expand_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [127:0] round_key
);
  import aes_pkg::*;

  logic [127:0] rk_q, rk_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] base;
  logic [7:0]   rc;
  logic [31:0]  rot, subw, t;
  logic [31:0]  w0, w1, w2, w3;

  assign base = kld ? key : rk_q;
  assign rc   = kld ? rcon(4'd1) : rcon(rc_q);
  assign rot  = {base[23:0], base[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    aes_sbox u_sbox (
      .a   (rot[31-8*j -: 8]),
      .y_c (subw[31-8*j -: 8])
    );
  end

  always_comb begin
    t    = subw ^ {rc, 24'h000000};
    w0   = base[127:96] ^ t;
    w1   = base[95:64] ^ w0;
    w2   = base[63:32] ^ w1;
    w3   = base[31:0] ^ w2;
    rk_d = rk_q;
    rc_d = rc_q;
    if (kld) begin
      rk_d = {w0, w1, w2, w3};
      rc_d = 4'd2;
    end else if (rc_q >= 4'd2 && rc_q <= 4'(NR)) begin
      rk_d = {w0, w1, w2, w3};
      rc_d = (rc_q == 4'(NR)) ? 4'd0 : rc_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rc_q <= 4'd0;
    else        rc_q <= rc_d;
  end

  always_ff @(posedge clk) begin
    rk_q <= rk_d;
  end

  assign round_key = rk_q;

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a constant lookup table.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  // Entry 0 occupies the top byte, so entry a lives at bit offset (255-a)*8 = ~a*8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_c = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_ctr_keystream.sv
// Iterative AES-128 CTR keystream generator: one key/IV load yields nblk blocks
// E_K(ctr_i) over a valid/ready interface, one block in flight at a time.
module aes_ctr_keystream #(
  parameter int unsigned CTR_W = 32,
  parameter int unsigned NB_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [127:0]    key,
  input  logic [127:0]    iv,
  input  logic [NB_W-1:0] nblk,
  output logic            busy,
  output logic            ks_valid,
  input  logic            ks_ready,
  output logic [127:0]    ks_data,
  output logic [NB_W-1:0] ks_idx,
  output logic            ks_last,
  output logic            done
);
  import aes_pkg::*;

  // Only the low CTR_W bits of the counter block take part in the increment.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

  state_e          st_q, st_d;
  logic            busy_q, busy_d;
  logic            ks_valid_q, ks_valid_d;
  logic            ks_last_q, ks_last_d;
  logic            done_q, done_d;
  logic            kld_q, kld_d;
  logic [NB_W-1:0] idx_q, idx_d;
  logic [3:0]      rnd_q, rnd_d;

  logic [NB_W-1:0] nblk_q, nblk_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    ctr_q, ctr_d;
  logic [127:0]    state_q, state_d;
  logic [127:0]    ks_data_q, ks_data_d;

  logic [127:0]    round_key;
  logic [127:0]    round_out_c;
  logic [127:0]    ctr_inc;

  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  aes_key_expand_128 u_kexp (
    .clk       (clk),
    .rst_n     (rst_n),
    .kld       (kld_q),
    .key       (key_q),
    .round_key (round_key)
  );

  aes_enc_round u_round (
    .state_in    (state_q),
    .round_key   (round_key),
    .final_round (rnd_q == 4'(NR)),
    .state_out_c (round_out_c)
  );

  always_comb begin
    st_d       = st_q;
    busy_d     = busy_q;
    ks_valid_d = ks_valid_q;
    ks_last_d  = ks_last_q;
    done_d     = 1'b0;
    kld_d      = 1'b0;
    idx_d      = idx_q;
    rnd_d      = rnd_q;
    nblk_d     = nblk_q;
    key_d      = key_q;
    ctr_d      = ctr_q;
    state_d    = state_q;
    ks_data_d  = ks_data_q;

    case (st_q)
      IDLE: begin
        if (start) begin
          key_d  = key;
          ctr_d  = iv;
          nblk_d = nblk;
          idx_d  = '0;
          busy_d = 1'b1;
          if (nblk == '0) begin
            done_d = 1'b1;
            st_d   = FIN;
          end else begin
            st_d = KLOAD;
          end
        end
      end
      KLOAD: begin
        kld_d   = 1'b1;
        state_d = ctr_q ^ key_q;
        rnd_d   = 4'd1;
        st_d    = RND;
      end
      RND: begin
        // The cycle with kld high lets the key schedule produce round key 1.
        if (!kld_q) begin
          state_d = round_out_c;
          rnd_d   = rnd_q + 4'd1;
          if (rnd_q == 4'(NR)) begin
            ks_data_d  = round_out_c;
            ks_valid_d = 1'b1;
            ks_last_d  = (idx_q == nblk_q - NB_W'(1));
            st_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (ks_ready) begin
          ks_valid_d = 1'b0;
          ks_last_d  = 1'b0;
          if (ks_last_q) begin
            done_d = 1'b1;
            st_d   = FIN;
          end else begin
            idx_d = idx_q + NB_W'(1);
            ctr_d = ctr_inc;
            st_d  = KLOAD;
          end
        end
      end
      FIN: begin
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= IDLE;
      busy_q     <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_last_q  <= 1'b0;
      done_q     <= 1'b0;
      kld_q      <= 1'b0;
      idx_q      <= '0;
      rnd_q      <= 4'd0;
    end else begin
      st_q       <= st_d;
      busy_q     <= busy_d;
      ks_valid_q <= ks_valid_d;
      ks_last_q  <= ks_last_d;
      done_q     <= done_d;
      kld_q      <= kld_d;
      idx_q      <= idx_d;
      rnd_q      <= rnd_d;
    end
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    nblk_q    <= nblk_d;
    key_q     <= key_d;
    ctr_q     <= ctr_d;
    state_q   <= state_d;
    ks_data_q <= ks_data_d;
  end

  assign busy     = busy_q;
  assign ks_valid = ks_valid_q;
  assign ks_last  = ks_last_q;
  assign done     = done_q;
  assign ks_idx   = idx_q;
  assign ks_data  = ks_data_q;

endmodule

// File: tb/tb_aes_ctr_keystream.sv
// Directed bench for aes_ctr_keystream: known-answer vector table plus
// hand-written reset, busy-start and zero-length sequences.
module tb_aes_ctr_keystream;

  localparam int unsigned CTR_W = 32;
  localparam int unsigned NB_W  = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [127:0]    key;
  logic [127:0]    iv;
  logic [NB_W-1:0] nblk;
  logic            busy;
  logic            ks_valid;
  logic            ks_ready;
  logic [127:0]    ks_data;
  logic [NB_W-1:0] ks_idx;
  logic            ks_last;
  logic            done;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] SP_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_IV    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  aes_ctr_keystream #(.CTR_W(CTR_W), .NB_W(NB_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .iv       (iv),
    .nblk     (nblk),
    .busy     (busy),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .ks_data  (ks_data),
    .ks_idx   (ks_idx),
    .ks_last  (ks_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [127:0]       key;
    logic [127:0]       iv;
    int                 nblk;
    int                 stall_blk;
    int                 stall_len;
    logic [3:0]         chk;
    logic [3:0][127:0]  exp;
  } vec_t;

  vec_t vecs[4];

  function automatic vec_t mk(input string nm, input logic [127:0] k, input logic [127:0] v,
                              input int n, input int sb, input int sl, input logic [3:0] chk,
                              input logic [127:0] e0, input logic [127:0] e1,
                              input logic [127:0] e2, input logic [127:0] e3);
    vec_t r;
    r.name = nm; r.key = k; r.iv = v; r.nblk = n;
    r.stall_blk = sb; r.stall_len = sl; r.chk = chk;
    r.exp = {e3, e2, e1, e0};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!ks_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    logic [127:0] cap;
    key = v.key; iv = v.iv; nblk = NB_W'(v.nblk); start = 1'b1; ks_ready = 1'b1;
    tick();
    start = 1'b0; key = ~v.key; iv = ~v.iv; nblk = NB_W'(v.nblk + 3);
    check({v.name, " busy_after_start"}, 128'(busy), 128'd1);
    for (int b = 0; b < v.nblk; b++) begin
      ks_ready = (b == v.stall_blk) ? 1'b0 : 1'b1;
      wait_valid(lat);
      check($sformatf("%s blk%0d latency", v.name, b), 128'(lat), 128'd12);
      if (v.chk[b]) check($sformatf("%s blk%0d data", v.name, b), ks_data, v.exp[b]);
      check($sformatf("%s blk%0d idx", v.name, b), 128'(ks_idx), 128'(b));
      check($sformatf("%s blk%0d last", v.name, b), 128'(ks_last), 128'(b == v.nblk - 1));
      if (b == v.stall_blk) begin
        cap = ks_data;
        for (int s = 0; s < v.stall_len; s++) begin
          tick();
          check($sformatf("%s blk%0d stall%0d", v.name, b, s),
                {ks_valid, ks_last, ks_idx, ks_data[117:0]},
                {1'b1, 1'(b == v.nblk - 1), NB_W'(b), cap[117:0]});
        end
        ks_ready = 1'b1;
      end
      tick();
      if (b == v.nblk - 1) begin
        check($sformatf("%s done_busy", v.name), 128'({ks_valid, done, busy}), 128'(3'b011));
        tick();
        check($sformatf("%s idle_after_done", v.name), 128'({ks_valid, done, busy}), 128'(3'b000));
      end else begin
        check($sformatf("%s blk%0d drop", v.name, b), 128'({ks_valid, done, busy}), 128'(3'b001));
      end
    end
  endtask

  initial begin
    int lat;
    vecs[0] = mk("fips", FIPS_KEY, FIPS_PT, 1, -1, 0, 4'b0001, FIPS_CT, '0, '0, '0);
    vecs[1] = mk("ctr4", SP_KEY, SP_IV, 4, -1, 0, 4'b1111,
                 128'hec8cdf7398607cb0f2d21675ea9ea1e4, 128'h362b7c3c6773516318a077d7fc5073ae,
                 128'h6a2cc3787889374fbeb4c81b17ba6c44, 128'he89c399ff0f198c6d40a31db156cabfe);
    vecs[2] = mk("ctr4_stall", SP_KEY, SP_IV, 4, 1, 5, 4'b1111,
                 128'hec8cdf7398607cb0f2d21675ea9ea1e4, 128'h362b7c3c6773516318a077d7fc5073ae,
                 128'h6a2cc3787889374fbeb4c81b17ba6c44, 128'he89c399ff0f198c6d40a31db156cabfe);
    // Zero key: block 1 wraps to the all-zero counter block, whose encryption is known.
    vecs[3] = mk("wrap", '0, 128'h000000000000000000000000ffffffff, 2, -1, 0, 4'b0010,
                 '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, '0);

    rst_n = 1'b0; start = 1'b0; key = '0; iv = '0; nblk = '0; ks_ready = 1'b1;
    tick(); tick();
    check("reset_ctrl", 128'({busy, ks_valid, ks_last, done}), 128'd0);
    check("reset_idx", 128'(ks_idx), 128'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Zero-length request: straight to FIN, no keystream.
    key = SP_KEY; iv = SP_IV; nblk = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("nblk0 fin", 128'({done, busy, ks_valid}), 128'(3'b110));
    tick();
    check("nblk0 idle", 128'({done, busy, ks_valid}), 128'(3'b000));

    // Start while busy must be dropped, not queued.
    key = FIPS_KEY; iv = FIPS_PT; nblk = NB_W'(1); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    key = '0; iv = '0; nblk = NB_W'(4); start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("busy_start data", ks_data, FIPS_CT);
    check("busy_start last", 128'({ks_last, ks_idx}), 128'({1'b1, NB_W'(0)}));
    tick();
    check("busy_start done", 128'({done, busy}), 128'(2'b11));
    repeat (4) tick();
    check("busy_start no_queue", 128'({busy, ks_valid}), 128'(2'b00));

    // Asynchronous reset during round 5.
    key = FIPS_KEY; iv = FIPS_PT; nblk = NB_W'(1); start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("rst_rnd busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rnd async", 128'({busy, ks_valid, done, ks_idx}), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset while a block is held under backpressure.
    ks_ready = 1'b0;
    key = FIPS_KEY; iv = FIPS_PT; nblk = NB_W'(2); start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("rst_hold valid_before", 128'(ks_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    check("rst_hold async", 128'({busy, ks_valid, ks_last, done}), 128'd0);
    tick();
    rst_n = 1'b1;
    ks_ready = 1'b1;
    tick();
    check("rst_hold idle", 128'({busy, ks_valid, done}), 128'd0);

    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
